// File: rtl/divisor_sequencial.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first,
// with a Start/Done handshake and a one-cycle divide-by-zero path.
module divisor_sequencial #(
   parameter int LARGURA = 16
) (
   input  logic               Clock_i,
   input  logic               Reset_i,
   input  logic               Start_i,
   input  logic [LARGURA-1:0] Dividendo_i,
   input  logic [LARGURA-1:0] Divisor_i,
   output logic [LARGURA-1:0] Quociente_o,
   output logic [LARGURA-1:0] Resto_o,
   output logic               Busy_o,
   output logic               Done_o,
   output logic               DivZero_o
);

   localparam int CW = $clog2(LARGURA) + 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIM
   } state_t;

   state_t             state_q, state_d;
   logic [LARGURA-1:0] dvd_q, dvd_d;
   logic [LARGURA-1:0] dvs_q, dvs_d;
   logic [LARGURA-1:0] acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [LARGURA-1:0] quo_q, quo_d;
   logic [LARGURA-1:0] rem_q, rem_d;
   logic               divz_q, divz_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [LARGURA-1:0] acc_sh;
   logic [LARGURA:0]   trial;
   logic               q_bit;

   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         divz_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         divz_q  <= divz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      divz_d  = divz_q;

      // The partial remainder never exceeds LARGURA-1 bits before the shift,
      // so the shifted value always fits in LARGURA bits.
      acc_sh = {acc_q[LARGURA-2:0], dvd_q[LARGURA-1]};
      trial  = {1'b0, acc_sh} - {1'b0, dvs_q};
      q_bit  = ~trial[LARGURA];

      case (state_q)
         IDLE: begin
            if (Start_i) begin
               if (Divisor_i != '0) begin
                  dvd_d   = Dividendo_i;
                  dvs_d   = Divisor_i;
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = CALC;
               end else begin
                  quo_d   = '1;
                  rem_d   = Dividendo_i;
                  divz_d  = 1'b1;
                  state_d = FIM;
               end
            end
         end
         CALC: begin
            acc_d = q_bit ? trial[LARGURA-1:0] : acc_sh;
            dvd_d = {dvd_q[LARGURA-2:0], q_bit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LARGURA - 1)) begin
               quo_d   = dvd_d;
               rem_d   = acc_d;
               divz_d  = 1'b0;
               state_d = FIM;
            end
         end
         FIM: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == FIM);
   end

   assign Quociente_o = quo_q;
   assign Resto_o     = rem_q;
   assign Busy_o      = busy_q;
   assign Done_o      = done_q;
   assign DivZero_o   = divz_q;

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: directed cases plus random
// operands against an arithmetic reference (a/b, a%b).
module tb_divisor_sequencial;

   logic        Clock;
   logic        Reset;
   logic        Start;
   logic [15:0] Dividendo;
   logic [15:0] Divisor;
   logic [15:0] Quociente;
   logic [15:0] Resto;
   logic        Busy;
   logic        Done;
   logic        DivZero;

   int vectors     = 0;
   int miscompares = 0;

   // Results of the last completed operation as the reference sees them.
   logic [15:0] exp_q = 16'h0;
   logic [15:0] exp_r = 16'h0;
   logic        exp_z = 1'b0;

   divisor_sequencial #(.LARGURA(16)) dut (
      .Clock_i     (Clock),
      .Reset_i     (Reset),
      .Start_i     (Start),
      .Dividendo_i (Dividendo),
      .Divisor_i   (Divisor),
      .Quociente_o (Quociente),
      .Resto_o     (Resto),
      .Busy_o      (Busy),
      .Done_o      (Done),
      .DivZero_o   (DivZero)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [15:0] a, input logic [15:0] b);
      @(negedge Clock);
      Dividendo = a;
      Divisor   = b;
      Start     = 1'b1;
      @(posedge Clock);
      #1;
      Start     = 1'b0;
      Dividendo = 16'($urandom);
      Divisor   = 16'($urandom);
   endtask

   // Counts negedges after the launch edge until Done; outputs must hold the
   // previous result until then.
   task automatic wait_done(output int cyc, output int busy_cnt);
      bit got;
      got = 0;
      cyc = 0;
      busy_cnt = 0;
      while (!got && cyc < 40) begin
         @(negedge Clock);
         cyc++;
         if (Busy) busy_cnt++;
         if (Done) got = 1;
         else begin
            chk("hold_q", 32'(Quociente), 32'(exp_q));
            chk("hold_r", 32'(Resto), 32'(exp_r));
            chk("hold_z", 32'(DivZero), 32'(exp_z));
         end
      end
      if (!got) chk("done_timeout", 32'(Done), 32'd1);
   endtask

   task automatic expect_result(input logic [15:0] a, input logic [15:0] b);
      if (b == 16'h0) begin
         exp_q = 16'hFFFF;
         exp_r = a;
         exp_z = 1'b1;
      end else begin
         exp_q = a / b;
         exp_r = a % b;
         exp_z = 1'b0;
      end
      chk("quociente", 32'(Quociente), 32'(exp_q));
      chk("resto", 32'(Resto), 32'(exp_r));
      chk("divzero", 32'(DivZero), 32'(exp_z));
      if (b != 16'h0) begin
         chk("identity", 32'(Quociente) * 32'(b) + 32'(Resto), 32'(a));
         chk("resto_lt_divisor", 32'(Resto < b), 32'd1);
      end
   endtask

   task automatic do_op(input logic [15:0] a, input logic [15:0] b);
      int cyc, bc, lat;
      lat = (b == 16'h0) ? 1 : 17;
      launch(a, b);
      wait_done(cyc, bc);
      chk("latency", 32'(cyc), 32'(lat));
      chk("busy_cycles", 32'(bc), 32'(lat));
      expect_result(a, b);
      @(negedge Clock);
      chk("done_single", 32'(Done), 32'd0);
      chk("busy_idle", 32'(Busy), 32'd0);
   endtask

   initial begin
      int cyc, bc;
      logic [15:0] a, b;
      Reset = 1'b1;
      Start = 1'b0;
      Dividendo = 16'h0;
      Divisor = 16'h0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      chk("rst_q", 32'(Quociente), 32'd0);
      chk("rst_r", 32'(Resto), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_divzero", 32'(DivZero), 32'd0);
      Reset = 1'b0;

      do_op(16'd100, 16'd7);
      do_op(16'hFFFF, 16'd1);
      do_op(16'd5, 16'd9);
      do_op(16'h8000, 16'h8000);
      do_op(16'd0, 16'd3);
      do_op(16'd1234, 16'd0);
      do_op(16'd10, 16'd3);

      // Start while busy: second request held high until accepted after FIM.
      launch(16'd200, 16'd9);
      repeat (4) @(negedge Clock);
      Start = 1'b1;
      Dividendo = 16'd50;
      Divisor = 16'd5;
      wait_done(cyc, bc);
      chk("busy_start_latency", 32'(cyc + 4), 32'd17);
      expect_result(16'd200, 16'd9);
      wait_done(cyc, bc);
      Start = 1'b0;
      chk("back_to_back_period", 32'(cyc), 32'd18);
      expect_result(16'd50, 16'd5);
      @(negedge Clock);
      chk("b2b_done_single", 32'(Done), 32'd0);

      // Reset in the middle of a calculation.
      launch(16'd1000, 16'd3);
      repeat (7) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      exp_q = 16'h0;
      exp_r = 16'h0;
      exp_z = 1'b0;
      chk("midrst_q", 32'(Quociente), 32'd0);
      chk("midrst_r", 32'(Resto), 32'd0);
      chk("midrst_busy", 32'(Busy), 32'd0);
      chk("midrst_divzero", 32'(DivZero), 32'd0);
      for (int i = 0; i < 20; i++) begin
         chk("midrst_no_done", 32'(Done), 32'd0);
         @(negedge Clock);
      end
      do_op(16'd9, 16'd2);

      for (int i = 0; i < 500; i++) begin
         a = 16'($urandom);
         if ($urandom_range(0, 1) == 0) b = 16'($urandom_range(1, 255));
         else b = 16'($urandom_range(1, 65535));
         do_op(a, b);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
